clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel programmable clock divider: the next generation of the single fixed-ratio toggle divider. Produces N_CH independent divided outputs from one fabric clock, each with a runtime-programmable period and high time (duty), plus a one-cycle period-start strobe per channel for use as a clock enable. Sits beside the HDMI timing logic to derive pixel, audio and slow housekeeping rates without extra clock domains. Ratio changes are glitch-free; a global SYNC realigns all channels.

## Interface
- N_CH, 4: number of channels (1..16)
- DIV_W, 8: width of period and high-time fields
- DEFAULT_DIV, 4: per-channel period loaded at reset (0..2^DIV_W-1)
- DEFAULT_HIGH, 2: per-channel high time loaded at reset
- CH_W, derived: max(1, clog2(N_CH))

- CLK  in  1  fabric clock; the single clock, all logic on its rising edge
- RST  in  1  reset, asynchronous, active-high
- SYNC  in  1  restart all channels at phase 0 on this edge
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted
- cfg_ch  in  CH_W  target channel
- cfg_div  in  DIV_W  new period in CLK cycles; 0 = channel disabled
- cfg_high  in  DIV_W  new high time in CLK cycles
- CLK_OUT  out  N_CH  registered divided outputs
- TICK  out  N_CH  registered one-cycle period-start strobes

## Operation
- Per channel: active (D, H), pending (D', H', pend flag), phase counter p (DIV_W bits).
- Enabled channel (D≥1): p counts 0..D-1, wraps to 0. Register update on each edge: TICK=(p_new==0), CLK_OUT=(p_new<H).
- H=0: CLK_OUT constant low. H≥D: constant high. D=1: TICK high every cycle.
- Disabled (D=0): p held 0, CLK_OUT=0, TICK=0.
- Config handshake: cfg_ready = ~pend[cfg_ch]. Transfer on edge where cfg_valid&&cfg_ready: D',H' captured, pend set. cfg_ch≥N_CH: cfg_ready=1, write accepted and discarded.
- Pending applied at the next period boundary: the edge where p_new would wrap to 0. That edge uses the new D,H (p_new=0, TICK=1, CLK_OUT=(0<H')). pend cleared on the same edge.
- Disabled channel with pending: applied on the next edge, p_new=0.
- Write on the same edge as a boundary: captured, applied at the following boundary, never the current one.
- SYNC high on an edge: every channel forced to p_new=0, pending applied first, TICK=1 for all enabled channels. SYNC held high: phase stays 0, TICK stays high.
- No glitch: CLK_OUT changes only on CLK edges; no partial high or low pulses from reprogramming.

## Timing
- RST asserted: immediately p=0, D=DEFAULT_DIV, H=DEFAULT_HIGH, pend=0, CLK_OUT=0, TICK=0, cfg_ready=1.
- First edge after RST release is phase 0: TICK high after edges 1, 1+D, 1+2D, …
- CLK_OUT/TICK latency: 0 cycles after the edge computing p_new; registered, no combinational path from inputs.
- cfg_ready deasserts the cycle after acceptance and reasserts the cycle after the boundary that applies it.
- RST mid-period or mid-pending: discards pending and returns to the reset state; no completion of the current period.

## Structure
- Package clk_div_pkg: DIV_W default, reset DEFAULT_DIV/DEFAULT_HIGH, a clog2-based CH_W helper.
- Sub-module clk_div_chan, one per channel via generate: phase counter, active/pending registers, output registers. Inputs are per-channel write strobe, SYNC, and data. The top module holds only cfg_ch decode and cfg_ready mux.

## Test plan
- Reset then free-run, defaults D=4,H=2 → CLK_OUT 1100 repeating from edge 1; TICK on edges 1,5,9; cfg_ready=1.
- Write ch1 D=6,H=3 at phase 1 → ch1 finishes current 4-cycle period, then 111000 repeating; TICK spacing 4 then 6; cfg_ready[ch1 path] low until that boundary; second write meanwhile stalls.
- Write ch0 D=0 → ch0 outputs 0 from next boundary. Then write D=1,H=1 → CLK_OUT=1 and TICK=1 every cycle from the next edge.
- Channels at D=3,5,7; pulse SYNC mid-period → all TICK high on the same edge; a pending write to ch2 is applied on that edge.
- Write cfg_ch=N_CH (out of range) → accepted, no channel changes. Edge-coincident write on a boundary → applied one period later.
- Assert RST for 1 cycle mid-period with pend=1 → outputs 0 immediately; defaults resumed from edge 1 after release; pending lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults and sizing helper for the multi-channel clock divider bank.
package clk_div_pkg;

  localparam int DIV_W_DEF        = 8;
  localparam int DEFAULT_DIV_DEF  = 4;
  localparam int DEFAULT_HIGH_DEF = 2;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, active and pending period/high-time,
// registered divided clock and period-start strobe.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
  parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_high,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] div, high, pend_div, pend_high, phase;
  logic [DIV_W-1:0] div_nxt, high_nxt, phase_nxt;
  logic             run, boundary, apply;

  // The first edge after reset restarts at phase 0, exactly like SYNC.
  always_comb begin
    boundary  = sync || !run || (div == '0) || (phase == div - DIV_W'(1));
    apply     = pend && boundary;
    div_nxt   = apply ? pend_div  : div;
    high_nxt  = apply ? pend_high : high;
    phase_nxt = boundary ? '0 : phase + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= DIV_W'(DEFAULT_DIV);
      high      <= DIV_W'(DEFAULT_HIGH);
      pend_div  <= '0;
      pend_high <= '0;
      pend      <= 1'b0;
      phase     <= '0;
      run       <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      run   <= 1'b1;
      div   <= div_nxt;
      high  <= high_nxt;
      phase <= phase_nxt;
      if (wr) begin
        pend_div  <= wr_div;
        pend_high <= wr_high;
      end
      pend    <= wr || (pend && !apply);
      tick    <= (div_nxt != '0) && (phase_nxt == '0);
      clk_out <= (div_nxt != '0) && (phase_nxt < high_nxt);
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable dividers sharing one clock; the top only
// decodes the config channel and muxes the per-channel ready.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
  parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF,
  parameter int CH_W         = ch_w(N_CH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SYNC,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  output logic [N_CH-1:0]   CLK_OUT,
  output logic [N_CH-1:0]   TICK
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;

  // Out-of-range channels stay ready so the write is taken and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < N_CH; i++)
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W        (DIV_W),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .sync    (SYNC),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .wr_high (cfg_high),
      .clk_out (CLK_OUT[g]),
      .tick    (TICK[g]),
      .pend    (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with hand-derived output sequences.
module tb_clk_div_bank;

  localparam int N_CH  = 3;
  localparam int DIV_W = 8;
  localparam int CH_W  = 2;

  logic              CLK = 1'b0;
  logic              RST, SYNC, cfg_valid, cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div, cfg_high;
  logic [N_CH-1:0]   CLK_OUT, TICK;

  int compared   = 0;
  int mismatched = 0;

  logic [N_CH-1:0] co_hist [0:15];
  logic [N_CH-1:0] tk_hist [0:15];

  clk_div_bank #(
    .N_CH         (N_CH),
    .DIV_W        (DIV_W),
    .DEFAULT_DIV  (4),
    .DEFAULT_HIGH (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SYNC      (SYNC),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .CLK_OUT   (CLK_OUT),
    .TICK      (TICK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      co_hist[i] = CLK_OUT;
      tk_hist[i] = TICK;
    end
  endtask

  // First captured edge ends up as the most significant bit.
  function automatic logic [31:0] seq(input int ch, input int n, input bit use_tick);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = {s[30:0], use_tick ? tk_hist[i][ch] : co_hist[i][ch]};
    return s;
  endfunction

  task automatic cfg(input int ch, input int d, input int h);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(d);
    cfg_high  = DIV_W'(h);
  endtask

  task automatic check_defaults(input string tag);
    run(8);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_clk"},  32'(co_hist[i]), (i % 4 < 2)  ? 32'h7 : 32'h0);
      check({tag, "_tick"}, 32'(tk_hist[i]), (i % 4 == 0) ? 32'h7 : 32'h0);
    end
  endtask

  initial begin
    RST = 1'b1; SYNC = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    #2;
    check("rst_clk",   32'(CLK_OUT),   32'h0);
    check("rst_tick",  32'(TICK),      32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h1);
    step(); step();
    RST = 1'b0;
    check_defaults("def");

    // Reprogram ch1 mid-period; a second write stalls until the boundary
    step();
    check("b_tick9", 32'(TICK), 32'h7);
    cfg(1, 6, 3);
    check("b_rdy_pre", 32'(cfg_ready), 32'h1);
    step();
    check("b_rdy_low", 32'(cfg_ready), 32'h0);
    cfg_div = 8'd2; cfg_high = 8'd1;
    step(); step();
    check("b_stall", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    run(7);
    check("b_ch1_clk",  seq(1, 7, 1'b0), 32'b1110001);
    check("b_ch1_tick", seq(1, 7, 1'b1), 32'b1000001);
    check("b_ch0_tick", seq(0, 7, 1'b1), 32'b1000100);
    check("b_rdy_back", 32'(cfg_ready), 32'h1);

    // Disable ch0, then run it at D=1
    cfg(0, 0, 0);
    step();
    cfg_valid = 1'b0;
    run(3);
    check("c_dis_clk",  seq(0, 3, 1'b0), 32'b000);
    check("c_dis_tick", seq(0, 3, 1'b1), 32'b000);
    cfg(0, 1, 1);
    step();
    cfg_valid = 1'b0;
    check("c_dis_hold", 32'(CLK_OUT[0]), 32'h0);
    run(3);
    check("c_d1_clk",  seq(0, 3, 1'b0), 32'b111);
    check("c_d1_tick", seq(0, 3, 1'b1), 32'b111);

    // SYNC realignment with pending writes
    cfg(0, 3, 1);
    step();
    cfg(1, 5, 2);
    step();
    cfg_valid = 1'b0;
    check("d_pend1", 32'(cfg_ready), 32'h0);
    SYNC = 1'b1;
    step();
    check("d_sync1_tick", 32'(TICK),      32'h7);
    check("d_sync1_clk",  32'(CLK_OUT),   32'h7);
    check("d_sync1_rdy",  32'(cfg_ready), 32'h1);
    SYNC = 1'b0;
    cfg(2, 7, 3);
    step();
    cfg_valid = 1'b0;
    check("d_pend2", 32'(cfg_ready), 32'h0);
    SYNC = 1'b1;
    step();
    check("d_sync2_tick", 32'(TICK),      32'h7);
    check("d_sync2_clk",  32'(CLK_OUT),   32'h7);
    check("d_sync2_rdy",  32'(cfg_ready), 32'h1);
    SYNC = 1'b0;
    run(7);
    check("d_ch0_clk",  seq(0, 7, 1'b0), 32'b0010010);
    check("d_ch0_tick", seq(0, 7, 1'b1), 32'b0010010);
    check("d_ch1_clk",  seq(1, 7, 1'b0), 32'b1000110);
    check("d_ch1_tick", seq(1, 7, 1'b1), 32'b0000100);
    check("d_ch2_clk",  seq(2, 7, 1'b0), 32'b1100001);
    check("d_ch2_tick", seq(2, 7, 1'b1), 32'b0000001);
    SYNC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("d_hold_tick", 32'(TICK),    32'h7);
      check("d_hold_clk",  32'(CLK_OUT), 32'h7);
    end
    SYNC = 1'b0;
    step();
    check("d_rel_clk",  32'(CLK_OUT), 32'b110);
    check("d_rel_tick", 32'(TICK),    32'h0);

    // Out-of-range write, then a write landing on a boundary edge
    cfg(3, 2, 1);
    check("e_oor_rdy", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      cfg_ch = CH_W'(c);
      #0;
      check("e_oor_nopend", 32'(cfg_ready), 32'h1);
    end
    cfg(0, 2, 2);
    step();
    cfg_valid = 1'b0;
    check("e_bnd_tick", 32'(TICK[0]),    32'h1);
    check("e_bnd_clk",  32'(CLK_OUT[0]), 32'h1);
    check("e_bnd_rdy",  32'(cfg_ready),  32'h0);
    run(5);
    check("e_ch0_clk",  seq(0, 5, 1'b0), 32'b00111);
    check("e_ch0_tick", seq(0, 5, 1'b1), 32'b00101);

    // Reset mid-period with a write still pending
    cfg(1, 3, 1);
    step();
    cfg_valid = 1'b0;
    check("f_pend", 32'(cfg_ready), 32'h0);
    RST = 1'b1;
    #1;
    check("f_rst_clk",  32'(CLK_OUT),   32'h0);
    check("f_rst_tick", 32'(TICK),      32'h0);
    check("f_rst_rdy",  32'(cfg_ready), 32'h1);
    step();
    RST = 1'b0;
    check_defaults("f_def");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
